// File: rtl/wait_state_data_memory.sv
// Word-addressed data memory behind a valid/ready request port. Each accepted request
// waits WAIT_CYCLES cycles and is then served in a single access cycle.
module wait_state_data_memory #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int SHIFT = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BE_W - 1);
  localparam logic [ADDR_W-1:0] DEPTH_W    = ADDR_W'(DEPTH);
  localparam logic [3:0]        WAIT_LAST  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   off;
  logic [ADDR_W-1:0]   word_off;
  logic [IDX_W-1:0]    idx;
  logic                addr_err;
  logic [DATA_W-1:0]   mem_word;
  logic [DATA_W-1:0]   merged_word;
  logic                mem_we;
  logic                accept;

  assign accept    = req_valid && (state_q == S_IDLE);
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Out-of-window offsets leave nonzero bits above the index, so nothing aliases.
  always_comb begin
    off      = addr_q - BASE;
    word_off = off >> SHIFT;
    idx      = word_off[IDX_W-1:0];
    addr_err = (addr_q < BASE) || (word_off >= DEPTH_W) || ((addr_q & ALIGN_MASK) != '0);
  end

  always_comb begin
    mem_word    = mem[idx];
    merged_word = mem_word;
    for (int b = 0; b < BE_W; b++) begin
      if (be_q[b]) begin
        merged_word[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
    mem_we = (state_q == S_ACCESS) && write_q && !addr_err;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= merged_word;
    end
  end

  // Holding registers only change on an accept; contents are irrelevant while idle.
  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (accept) begin
      write_d = req_write;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      be_d    = req_be;
    end
  end

  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cnt_d = '0;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACCESS: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = addr_err;
        rsp_rdata_d = (!write_q && !addr_err) ? mem_word : '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_wait_state_data_memory.sv
// Directed bench for wait_state_data_memory: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance, with a scoreboard that models the memory and the response latency.
module tb_wait_state_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  always #5 clk = ~clk;

  wait_state_data_memory #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0])
  );

  wait_state_data_memory #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1])
  );

  typedef struct {
    int          k;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          acc;
  } txn_t;

  txn_t        sbq [$];
  logic [31:0] model [2][64];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Responses are retired before accepts so a same-cycle accept sees the updated model.
  always @(negedge clk) begin
    txn_t        t;
    logic        e_err;
    logic [31:0] e_rd;
    int          idx;
    if (rst !== 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        if (rsp_valid[k] === 1'b1) begin
          chk($sformatf("rsp_expected%0d", k), (sbq.size() > 0 && sbq[0].k == k), 1);
          if (sbq.size() > 0 && sbq[0].k == k) begin
            t     = sbq.pop_front();
            e_err = (t.addr < 32'd1024) || (t.addr >= 32'd1280) || (t.addr[1:0] != 2'b00);
            idx   = int'((t.addr - 32'd1024) >> 2);
            e_rd  = '0;
            if (t.wr) begin
              if (!e_err) begin
                for (int b = 0; b < 4; b++) begin
                  if (t.be[b]) model[k][idx][8*b +: 8] = t.wdata[8*b +: 8];
                end
              end
            end else if (!e_err) begin
              e_rd = model[k][idx];
            end
            chk($sformatf("latency%0d@%0d", k, t.addr), cyc - t.acc + 1, (k == 0) ? 4 : 2);
            chk($sformatf("rdata%0d@%0d", k, t.addr), rsp_rdata[k], e_rd);
            chk($sformatf("err%0d@%0d", k, t.addr), rsp_err[k], e_err);
            chk($sformatf("busy_in_rsp%0d", k), busy[k], 0);
          end
        end
        if (req_valid[k] === 1'b1 && req_ready[k] === 1'b1) begin
          sbq.push_back('{k, req_write[k], req_addr[k], req_wdata[k], req_be[k], cyc + 1});
        end
      end
    end
  end

  task automatic send(int k, logic wr, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_be[k]    = be;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[k] === 1'b1) break;
    end
    chk("accept_timeout", req_ready[k], 1);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_addr[k]  = 32'hFFFF_FFFF;
    req_wdata[k] = $urandom;
    req_be[k]    = 4'hF;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (sbq.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_timeout", sbq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(int k);
    chk($sformatf("rst_ready%0d", k), req_ready[k], 1);
    chk($sformatf("rst_rsp_valid%0d", k), rsp_valid[k], 0);
    chk($sformatf("rst_rdata%0d", k), rsp_rdata[k], 0);
    chk($sformatf("rst_err%0d", k), rsp_err[k], 0);
    chk($sformatf("rst_busy%0d", k), busy[k], 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      req_be[k]    = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic write then read back
    send(0, 1'b1, 32'd1024, 32'hDEADBEEF, 4'hF);
    wait_idle();
    send(0, 1'b0, 32'd1024, 32'h0, 4'hF);
    wait_idle();

    // Byte-enable merge
    send(0, 1'b1, 32'd1028, 32'h11223344, 4'hF);
    wait_idle();
    send(0, 1'b1, 32'd1028, 32'hAABBCCDD, 4'b0101);
    wait_idle();
    send(0, 1'b0, 32'd1028, 32'h0, 4'h0);
    wait_idle();
    chk("merge_model", model[0][1], 32'h11BB33DD);

    // Bad addresses, be=0 write, and the last valid word
    send(0, 1'b0, 32'd1020, 32'h0, 4'hF);
    send(0, 1'b0, 32'd1280, 32'h0, 4'hF);
    send(0, 1'b0, 32'd1026, 32'h0, 4'hF);
    send(0, 1'b1, 32'd1280, 32'h12345678, 4'hF);
    send(0, 1'b1, 32'd1024, 32'h0BAD0BAD, 4'h0);
    send(0, 1'b0, 32'd1024, 32'h0, 4'hF);
    send(0, 1'b1, 32'd1276, 32'hCAFEF00D, 4'hF);
    send(0, 1'b0, 32'd1276, 32'h0, 4'hF);
    wait_idle();

    // Held request while busy: second read waits for req_ready
    send(0, 1'b0, 32'd1024, 32'h0, 4'hF);
    chk("busy_after_accept", busy[0], 1);
    chk("ready_after_accept", req_ready[0], 0);
    send(0, 1'b0, 32'd1028, 32'h0, 4'hF);
    wait_idle();

    // Reset during WAIT of a write drops it
    send(0, 1'b1, 32'd1032, 32'h0, 4'hF);
    wait_idle();
    send(0, 1'b1, 32'd1032, 32'h5A5A5A5A, 4'hF);
    rst = 1'b1;
    #1;
    chk_reset_outputs(0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    send(0, 1'b0, 32'd1032, 32'h0, 4'hF);
    wait_idle();

    // Zero-wait instance
    send(1, 1'b1, 32'd1024, 32'h13579BDF, 4'hF);
    wait_idle();
    send(1, 1'b0, 32'd1024, 32'h0, 4'hF);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
